// File: rtl/wb_ctrl.sv
// Write-back stage: merges ex results with buffered multi-cycle results onto the regfile port.
// Latency 1 to reg_*_o; ex never stalls, mc is throttled by mc_ready_o when the FIFO is full.
module wb_ctrl #(
   parameter int DEPTH = 4,
   parameter int AW    = 5,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ex_wen_i,
   input  logic [AW-1:0] ex_waddr_i,
   input  logic [DW-1:0] ex_wdata_i,
   input  logic          mc_valid_i,
   output logic          mc_ready_o,
   input  logic [AW-1:0] mc_waddr_i,
   input  logic [DW-1:0] mc_wdata_i,
   input  logic [AW-1:0] hz_raddr1_i,
   input  logic [AW-1:0] hz_raddr2_i,
   output logic          hz_stall_o,
   output logic          reg_wen_o,
   output logic [AW-1:0] reg_waddr_o,
   output logic [DW-1:0] reg_wdata_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   typedef struct packed {
      logic          vld;
      logic [AW-1:0] addr;
      logic [DW-1:0] dat;
   } ent_t;

   ent_t          fifo_q [DEPTH];
   ent_t          fifo_d [DEPTH];
   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          reg_wen_q, reg_wen_d;
   logic [AW-1:0] reg_waddr_q, reg_waddr_d;
   logic [DW-1:0] reg_wdata_q, reg_wdata_d;

   logic ex_act, push, pop;

   always_comb begin
      ex_act     = ex_wen_i && (ex_waddr_i != '0);
      mc_ready_o = rst && (cnt_q != CW'(DEPTH));
      push       = mc_valid_i && mc_ready_o && (mc_waddr_i != '0);
      pop        = !ex_act && (cnt_q != '0);

      // ex is youngest: any buffered write to the same rd becomes stale
      for (int i = 0; i < DEPTH; i++) begin
         fifo_d[i] = fifo_q[i];
         if (ex_act && fifo_q[i].addr == ex_waddr_i)
            fifo_d[i].vld = 1'b0;
      end
      if (pop)
         fifo_d[head_q].vld = 1'b0;
      if (push) begin
         fifo_d[tail_q].vld  = !(ex_act && mc_waddr_i == ex_waddr_i);
         fifo_d[tail_q].addr = mc_waddr_i;
         fifo_d[tail_q].dat  = mc_wdata_i;
      end

      head_d = head_q + PW'(pop);
      tail_d = tail_q + PW'(push);
      cnt_d  = cnt_q + CW'(push) - CW'(pop);

      reg_wen_d   = 1'b0;
      reg_waddr_d = reg_waddr_q;
      reg_wdata_d = reg_wdata_q;
      if (ex_act) begin
         reg_wen_d   = 1'b1;
         reg_waddr_d = ex_waddr_i;
         reg_wdata_d = ex_wdata_i;
      end else if (pop && fifo_q[head_q].vld) begin
         reg_wen_d   = 1'b1;
         reg_waddr_d = fifo_q[head_q].addr;
         reg_wdata_d = fifo_q[head_q].dat;
      end

      hz_stall_o = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (fifo_q[i].vld &&
             ((fifo_q[i].addr == hz_raddr1_i && hz_raddr1_i != '0) ||
              (fifo_q[i].addr == hz_raddr2_i && hz_raddr2_i != '0)))
            hz_stall_o = rst;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
         head_q      <= '0;
         tail_q      <= '0;
         cnt_q       <= '0;
         reg_wen_q   <= 1'b0;
         reg_waddr_q <= '0;
         reg_wdata_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) fifo_q[i] <= fifo_d[i];
         head_q      <= head_d;
         tail_q      <= tail_d;
         cnt_q       <= cnt_d;
         reg_wen_q   <= reg_wen_d;
         reg_waddr_q <= reg_waddr_d;
         reg_wdata_q <= reg_wdata_d;
      end
   end

   assign reg_wen_o   = reg_wen_q;
   assign reg_waddr_o = reg_waddr_q;
   assign reg_wdata_o = reg_wdata_q;

endmodule

// File: tb/tb_wb_ctrl.sv
// Bench for wb_ctrl: directed stimulus, expected regfile writes queued and checked by a monitor.
module tb_wb_ctrl;
   localparam int AW = 5;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          ex_wen_i;
   logic [AW-1:0] ex_waddr_i;
   logic [DW-1:0] ex_wdata_i;
   logic          mc_valid_i;
   logic          mc_ready_o;
   logic [AW-1:0] mc_waddr_i;
   logic [DW-1:0] mc_wdata_i;
   logic [AW-1:0] hz_raddr1_i;
   logic [AW-1:0] hz_raddr2_i;
   logic          hz_stall_o;
   logic          reg_wen_o;
   logic [AW-1:0] reg_waddr_o;
   logic [DW-1:0] reg_wdata_o;

   always #5 clk = ~clk;

   wb_ctrl #(.DEPTH(4), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst),
      .ex_wen_i(ex_wen_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
      .mc_valid_i(mc_valid_i), .mc_ready_o(mc_ready_o),
      .mc_waddr_i(mc_waddr_i), .mc_wdata_i(mc_wdata_i),
      .hz_raddr1_i(hz_raddr1_i), .hz_raddr2_i(hz_raddr2_i), .hz_stall_o(hz_stall_o),
      .reg_wen_o(reg_wen_o), .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o)
   );

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   wr_t exp_q[$];
   wr_t mon_e;
   int  errors = 0;
   int  checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Monitor: every regfile write must match the oldest expected write
   always @(negedge clk) begin
      if (reg_wen_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got x%0d=%0h, expected no write", reg_waddr_o, reg_wdata_o);
         end else begin
            mon_e = exp_q.pop_front();
            chk("wr_addr", 64'(reg_waddr_o), 64'(mon_e.a));
            chk("wr_data", 64'(reg_wdata_o), 64'(mon_e.d));
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ex_wen_i   = 1'b0;
      mc_valid_i = 1'b0;
   endtask

   task automatic ex(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit expect_wr);
      ex_wen_i   = 1'b1;
      ex_waddr_i = a;
      ex_wdata_i = d;
      if (expect_wr) exp_q.push_back({a, d});
   endtask

   task automatic mc(input logic [AW-1:0] a, input logic [DW-1:0] d);
      mc_valid_i = 1'b1;
      mc_waddr_i = a;
      mc_wdata_i = d;
   endtask

   task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      exp_q.push_back({a, d});
   endtask

   initial begin
      rst = 1'b0; ex_wen_i = 1'b0; ex_waddr_i = '0; ex_wdata_i = '0;
      mc_valid_i = 1'b0; mc_waddr_i = '0; mc_wdata_i = '0;
      hz_raddr1_i = 5'd3; hz_raddr2_i = '0;
      cyc(); cyc();
      chk("rst_wen", 64'(reg_wen_o), 64'd0);
      chk("rst_waddr", 64'(reg_waddr_o), 64'd0);
      chk("rst_wdata", 64'(reg_wdata_o), 64'd0);
      chk("rst_ready", 64'(mc_ready_o), 64'd0);
      chk("rst_stall", 64'(hz_stall_o), 64'd0);
      rst = 1'b1; hz_raddr1_i = '0;
      #1 chk("ready_after_rst", 64'(mc_ready_o), 64'd1);

      // 1: single ex write, visible for exactly one cycle
      ex(5'd5, 32'hA5A5A5A5, 1'b1);
      cyc(); idle();
      chk("t1_wen_n1", 64'(reg_wen_o), 64'd1);
      cyc();
      chk("t1_wen_n2", 64'(reg_wen_o), 64'd0);
      chk("t1_hold_addr", 64'(reg_waddr_o), 64'd5);

      // 2: mc push drains two cycles later; hazard while buffered
      mc(5'd3, 32'h11); hz_raddr1_i = 5'd3;
      #1 chk("t2_stall_pre", 64'(hz_stall_o), 64'd0);
      expect_wr(5'd3, 32'h11);
      cyc(); idle();
      chk("t2_stall_buf", 64'(hz_stall_o), 64'd1);
      chk("t2_wen_n1", 64'(reg_wen_o), 64'd0);
      cyc();
      chk("t2_wen_n2", 64'(reg_wen_o), 64'd1);
      chk("t2_stall_done", 64'(hz_stall_o), 64'd0);
      hz_raddr1_i = '0;

      // 3: ex and mc in the same cycle; ex first
      ex(5'd7, 32'd1, 1'b1); mc(5'd8, 32'd2); expect_wr(5'd8, 32'd2);
      cyc(); idle();
      chk("t3_first", 64'(reg_waddr_o), 64'd7);
      cyc();
      chk("t3_second", 64'(reg_waddr_o), 64'd8);
      cyc();

      // 4: fill FIFO under continuous ex traffic, then drain in order
      for (int i = 0; i < 4; i++) begin
         ex(5'd9, 32'h900 + 32'(i), 1'b1);
         mc(5'(16 + i), 32'h100 + 32'(i));
         cyc();
      end
      mc(5'd20, 32'h1FF);
      #1 chk("t4_full", 64'(mc_ready_o), 64'd0);
      hz_raddr2_i = 5'd18;
      #1 chk("t4_stall_r2", 64'(hz_stall_o), 64'd1);
      ex(5'd9, 32'h904, 1'b1);
      cyc(); idle(); hz_raddr2_i = '0;
      for (int i = 0; i < 4; i++) expect_wr(5'(16 + i), 32'h100 + 32'(i));
      chk("t4_no_passthru", 64'(mc_ready_o), 64'd0);
      cyc();
      chk("t4_ready_back", 64'(mc_ready_o), 64'd1);
      repeat (4) cyc();

      // 5: younger ex to the same rd kills the buffered mc value
      mc(5'd4, 32'hAA);
      cyc(); idle();
      ex(5'd4, 32'hBB, 1'b1); hz_raddr1_i = 5'd4;
      #1 chk("t5_stall_live", 64'(hz_stall_o), 64'd1);
      cyc(); idle();
      chk("t5_stall_stale", 64'(hz_stall_o), 64'd0);
      cyc();
      chk("t5_stale_pop", 64'(reg_wen_o), 64'd0);
      hz_raddr1_i = '0;
      // same-cycle push and ex to the same rd
      ex(5'd6, 32'h66, 1'b1); mc(5'd6, 32'h55);
      cyc(); idle();
      repeat (2) cyc();

      // x0 handling: mc to x0 dropped, ex to x0 does not block the drain
      mc(5'd0, 32'hDEAD);
      cyc();
      mc(5'd2, 32'h22);
      cyc(); idle();
      ex(5'd0, 32'hBAD, 1'b0); expect_wr(5'd2, 32'h22);
      cyc(); idle();
      chk("x0_drain", 64'(reg_waddr_o), 64'd2);
      repeat (2) cyc();

      // 6: reset with three buffered entries discards them
      for (int i = 0; i < 3; i++) begin
         ex(5'd9, 32'hA00 + 32'(i), 1'b1);
         mc(5'(10 + i), 32'hC00 + 32'(i));
         cyc();
      end
      idle(); hz_raddr1_i = 5'd11;
      #1 chk("t6_stall_pre", 64'(hz_stall_o), 64'd1);
      rst = 1'b0;
      #1 chk("t6_ready_in_rst", 64'(mc_ready_o), 64'd0);
      chk("t6_stall_in_rst", 64'(hz_stall_o), 64'd0);
      cyc();
      chk("t6_wen", 64'(reg_wen_o), 64'd0);
      chk("t6_waddr", 64'(reg_waddr_o), 64'd0);
      chk("t6_wdata", 64'(reg_wdata_o), 64'd0);
      rst = 1'b1;
      #1 chk("t6_ready_after", 64'(mc_ready_o), 64'd1);
      chk("t6_stall_after", 64'(hz_stall_o), 64'd0);
      repeat (5) cyc();

      chk("exp_drained", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
